// File: rtl/shift_add_multiplier_if.sv
// Bundles the multiplier's control handshake, operands, product and the
// external adder port pair. The multiplier uses the slave modport; its environment uses master.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_s;
    logic             add_carry;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;

    modport slave (
        input  start, op_a, op_b, add_s, add_carry,
        output add_a, add_b, add_cin, busy, done, prod_hi, prod_lo
    );

    modport master (
        output start, op_a, op_b, add_s, add_carry,
        input  add_a, add_b, add_cin, busy, done, prod_hi, prod_lo
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-add multiplier driving an external adder.
// Optional macro MULT_EARLY_TERM_EN: finish early once the remaining multiplier bits are zero.
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_add_multiplier_if.slave mul_if,
    output logic [1:0]           o_dbg_state
);
    // Handshake: start is sampled only in IDLE; busy is high in RUN and DONE;
    // done is high for exactly one cycle (DONE) with prod_hi/prod_lo valid, and
    // the product holds until the next accepted start.
    localparam int              CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   L_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_m;
    logic [CW-1:0]      r_cnt;
    logic               w_last_step;
    logic               w_early;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod_nxt;

    // The adder's carry-out becomes the new ACC MSB, so ACC never overflows.
    assign w_step      = {mul_if.add_carry, mul_if.add_s, r_q[WIDTH-1:1]};
    assign w_last_step = (r_cnt == L_LAST);

`ifdef MULT_EARLY_TERM_EN
    localparam logic [CW:0] L_WIDTH = (CW+1)'(WIDTH);
    logic [WIDTH-1:0] w_rem_mask;
    logic [CW:0]      w_shamt;

    // Unprocessed multiplier bits sit in the low WIDTH-cnt bits of Q.
    assign w_rem_mask = {WIDTH{1'b1}} >> r_cnt;
    assign w_early    = ((r_q & w_rem_mask) == '0);
    assign w_shamt    = L_WIDTH - {1'b0, r_cnt};
    assign w_prod_nxt = w_early ? ({r_acc, r_q} >> w_shamt) : w_step;
`else
    assign w_early    = 1'b0;
    assign w_prod_nxt = w_step;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (mul_if.start) w_state_nxt = S_RUN;
            S_RUN:  if (w_last_step || w_early) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mul_if.start) begin
                        r_acc <= '0;
                        r_q   <= mul_if.op_b;
                        r_m   <= mul_if.op_a;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    {r_acc, r_q} <= w_prod_nxt;
                    r_cnt        <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mul_if.add_a   = r_acc;
    assign mul_if.add_b   = r_q[0] ? r_m : '0;
    assign mul_if.add_cin = 1'b0;
    assign mul_if.busy    = (r_state != S_IDLE);
    assign mul_if.done    = (r_state == S_DONE);
    assign mul_if.prod_hi = r_acc;
    assign mul_if.prod_lo = r_q;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: vector table, random operands,
// ignored-start, reset-abort and back-to-back sequences.
module tb_shift_add_multiplier;
    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] p;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         dbg_state;
    int                 n_checks = 0;
    int                 n_fail = 0;
    logic [2*WIDTH-1:0] exp_q[$];
    vec_t               vecs[10];

    shift_add_multiplier_if #(.WIDTH(WIDTH)) mif();

    // External adder
    assign {mif.add_carry, mif.add_s} = {1'b0, mif.add_a} + {1'b0, mif.add_b}
                                      + {{WIDTH{1'b0}}, mif.add_cin};

    shift_add_multiplier #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mul_if      (mif),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [2*WIDTH-1:0] ref_prod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] wa;
        logic [2*WIDTH-1:0] wb;
        wa = {{WIDTH{1'b0}}, a};
        wb = {{WIDTH{1'b0}}, b};
        return wa * wb;
    endfunction

    // Clock edges from the accepted start edge to the edge that raises done.
    function automatic int ref_latency(input logic [WIDTH-1:0] b);
`ifdef MULT_EARLY_TERM_EN
        int k;
        k = -1;
        for (int i = 0; i < WIDTH; i++) if (b[i]) k = i;
        if (k < 0) return 1;
        return (k + 2 > WIDTH) ? WIDTH : k + 2;
`else
        return WIDTH;
`endif
    endfunction

    // Called aligned to a negedge; returns at the negedge of the IDLE cycle after done.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2*WIDTH-1:0] exp_p, input string tag);
        int lat;
        int exp_lat;
        logic [2*WIDTH-1:0] exp;
        exp_q.push_back(exp_p);
        exp_lat = ref_latency(b);
        mif.op_a  = a;
        mif.op_b  = b;
        mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        mif.op_a  = $urandom;
        mif.op_b  = $urandom;
        check({tag, "_busy_run"}, 64'(mif.busy), 64'd1);
        lat = 0;
        while (!mif.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        exp = exp_q.pop_front();
        if (!mif.done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout got=no_done exp=done", tag);
        end else begin
            check({tag, "_prod"}, {mif.prod_hi, mif.prod_lo}, exp);
            check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
            check({tag, "_busy_done"}, 64'(mif.busy), 64'd1);
            @(negedge clk);
            check({tag, "_done_pulse"}, {62'd0, mif.busy, mif.done}, 64'd0);
            check({tag, "_hold"}, {mif.prod_hi, mif.prod_lo}, exp);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int n_done;
        logic [2*WIDTH-1:0] cap;

        vecs[0] = '{32'd3,         32'd5,         64'h00000000_0000000F};
        vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001};
        vecs[2] = '{32'h12345678,  32'h9ABCDEF0,  64'h0B00EA4E_242D2080};
        vecs[3] = '{32'd0,         32'hFFFFFFFF,  64'h0};
        vecs[4] = '{32'hFFFFFFFF,  32'd0,         64'h0};
        vecs[5] = '{32'd1,         32'd1,         64'h1};
        vecs[6] = '{32'd7,         32'd1,         64'h7};
        vecs[7] = '{32'd7,         32'd0,         64'h0};
        vecs[8] = '{32'h80000000,  32'h80000000,  64'h40000000_00000000};
        vecs[9] = '{32'hFFFFFFFF,  32'd2,         64'h00000001_FFFFFFFE};

        mif.start = 1'b0;
        mif.op_a  = '0;
        mif.op_b  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(mif.busy), 64'd0);
        check("rst_done", 64'(mif.done), 64'd0);
        check("rst_hi", 64'(mif.prod_hi), 64'd0);
        check("rst_lo", 64'(mif.prod_lo), 64'd0);
        check("rst_cin", 64'(mif.add_cin), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, issued back-to-back
        for (int i = 0; i < 10; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

        // Random operands, some with sparse multipliers
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 1) rb = rb >> $urandom_range(0, WIDTH - 1);
            if (i % 6 == 5) rb = '0;
            run_op(ra, rb, ref_prod(ra, rb), $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Starts while busy are ignored; exactly one done pulse
        mif.op_a  = 32'h12345678;
        mif.op_b  = 32'h9ABCDEF0;
        mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        n_done = 0;
        cap = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (mif.done) begin
                n_done++;
                cap = {mif.prod_hi, mif.prod_lo};
            end
            mif.start = (i == 5 || i == 32);
            mif.op_a  = $urandom;
            mif.op_b  = $urandom;
        end
        mif.start = 1'b0;
        check("ign_ndone", 64'(n_done), 64'd1);
        check("ign_prod", cap, 64'h0B00EA4E_242D2080);
        check("ign_idle", 64'(mif.busy), 64'd0);

        // Reset mid-operation aborts immediately
        mif.op_a  = 32'hFFFFFFFF;
        mif.op_b  = 32'hFFFFFFFF;
        mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(mif.busy), 64'd0);
        check("abort_done", 64'(mif.done), 64'd0);
        check("abort_prod", {mif.prod_hi, mif.prod_lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ra = $urandom;
        rb = $urandom | 32'h80000000;
        run_op(ra, rb, ref_prod(ra, rb), "post_rst");

        // Back-to-back: 2x3 then 4x4 started in the IDLE cycle after done
        run_op(32'd2, 32'd3, 64'd6, "b2b_first");
        check("b2b_hold6", {mif.prod_hi, mif.prod_lo}, 64'd6);
        run_op(32'd4, 32'd4, 64'd16, "b2b_second");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
